// File: rtl/cache_refill_ctrl.sv
`timescale 1ns/1ps
// Cache refill controller.
// A read miss is accepted in IDLE. The controller then fetches the four
// 16-bit words of the line from main memory, writes the assembled line into
// the chosen victim way, and returns the requested word to the CPU.
// Victim choice: the lowest-numbered invalid way, or else the set's
// round-robin pointer when all four ways are valid.
module cache_refill_ctrl #(
   parameter int TAG_W = 10,
   parameter int IDX_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic [TAG_W+IDX_W+1:0]   req_addr,
   input  logic                     hit,
   input  logic [3:0]               valid_vec,
   output logic                     req_ready,
   output logic                     mem_rd_req,
   output logic [TAG_W+IDX_W+1:0]   mem_addr,
   input  logic                     mem_ack,
   input  logic [15:0]              mem_data,
   output logic                     fill_we,
   output logic [1:0]               fill_way,
   output logic [IDX_W-1:0]         fill_index,
   output logic [TAG_W-1:0]         fill_tag,
   output logic [63:0]              fill_line,
   output logic                     resp_valid,
   output logic [15:0]              resp_data
);

   typedef enum logic [1:0] {IDLE, FETCH, WRITE, RESP} state_e;

   state_e            state_q, state_d;
   logic [TAG_W-1:0]  tag_q;
   logic [IDX_W-1:0]  index_q;
   logic [1:0]        word_q;
   logic [1:0]        way_q;
   logic              fromRr_q;
   logic [1:0]        count_q;
   logic [63:0]       line_q;
   logic [15:0]       respData_q;
   logic [1:0]        rrPtr_q [2**IDX_W];

   logic [TAG_W-1:0]  reqTag;
   logic [IDX_W-1:0]  reqIndex;
   logic [1:0]        reqWord;
   logic [1:0]        victimWay;
   logic              victimFromRr;
   logic              accept;

   assign reqTag   = req_addr[TAG_W+IDX_W+1:IDX_W+2];
   assign reqIndex = req_addr[IDX_W+1:2];
   assign reqWord  = req_addr[1:0];
   assign accept   = (state_q == IDLE) && req_valid && !hit;

   // Victim choice: fill an empty way first; only a full set falls back to
   // the round-robin pointer, and only that case advances the pointer later.
   always_comb begin
      victimWay    = 2'd0;
      victimFromRr = 1'b0;
      if (!valid_vec[0]) begin
         victimWay = 2'd0;
      end else if (!valid_vec[1]) begin
         victimWay = 2'd1;
      end else if (!valid_vec[2]) begin
         victimWay = 2'd2;
      end else if (!valid_vec[3]) begin
         victimWay = 2'd3;
      end else begin
         victimWay    = rrPtr_q[reqIndex];
         victimFromRr = 1'b1;
      end
   end

   // State register; an asynchronous reset abandons any refill in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and strobe decode. The strobes are pure state decodes, so
   // they drop as soon as reset forces the state back to IDLE.
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      mem_rd_req = 1'b0;
      fill_we    = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid && !hit) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            mem_rd_req = 1'b1;
            if (mem_ack && (count_q == 2'd3)) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            fill_we = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath. Latch the miss at acceptance, collect one word per acked
   // FETCH cycle into lane k, and pick the requested word out of the
   // finished line on the way into RESP. Values hold outside those events.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_q      <= '0;
         index_q    <= '0;
         word_q     <= '0;
         way_q      <= '0;
         fromRr_q   <= 1'b0;
         count_q    <= '0;
         line_q     <= '0;
         respData_q <= '0;
      end else begin
         if (accept) begin
            tag_q    <= reqTag;
            index_q  <= reqIndex;
            word_q   <= reqWord;
            way_q    <= victimWay;
            fromRr_q <= victimFromRr;
            count_q  <= 2'd0;
         end
         if ((state_q == FETCH) && mem_ack) begin
            line_q[{count_q, 4'b0000} +: 16] <= mem_data;
            if (count_q != 2'd3) begin
               count_q <= count_q + 2'd1;
            end
         end
         if (state_q == WRITE) begin
            respData_q <= line_q[{word_q, 4'b0000} +: 16];
         end
      end
   end

   // Per-set round-robin pointers. A pointer advances only when the line
   // just written replaced the way that pointer selected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**IDX_W; i++) begin
            rrPtr_q[i] <= 2'd0;
         end
      end else if ((state_q == WRITE) && fromRr_q) begin
         rrPtr_q[index_q] <= rrPtr_q[index_q] + 2'd1;
      end
   end

   assign mem_addr   = {tag_q, index_q, count_q};
   assign fill_way   = way_q;
   assign fill_index = index_q;
   assign fill_tag   = tag_q;
   assign fill_line  = line_q;
   assign resp_data  = respData_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
`timescale 1ns/1ps
// Directed testbench for cache_refill_ctrl. Expected values are written
// out by hand for each miss: the address sequence, the victim way, the
// assembled line and the returned word.
module tb_cache_refill_ctrl;

   localparam int TAG_W = 10;
   localparam int IDX_W = 4;
   localparam int A     = TAG_W + IDX_W + 2;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic [A-1:0]      req_addr;
   logic              hit;
   logic [3:0]        valid_vec;
   logic              req_ready;
   logic              mem_rd_req;
   logic [A-1:0]      mem_addr;
   logic              mem_ack;
   logic [15:0]       mem_data;
   logic              fill_we;
   logic [1:0]        fill_way;
   logic [IDX_W-1:0]  fill_index;
   logic [TAG_W-1:0]  fill_tag;
   logic [63:0]       fill_line;
   logic              resp_valid;
   logic [15:0]       resp_data;

   int checks    = 0;
   int failures  = 0;
   int fillCount = 0;
   int respCount = 0;

   cache_refill_ctrl #(.TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .hit        (hit),
      .valid_vec  (valid_vec),
      .req_ready  (req_ready),
      .mem_rd_req (mem_rd_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_data   (mem_data),
      .fill_we    (fill_we),
      .fill_way   (fill_way),
      .fill_index (fill_index),
      .fill_tag   (fill_tag),
      .fill_line  (fill_line),
      .resp_valid (resp_valid),
      .resp_data  (resp_data)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count write and response pulses mid-cycle so that any extra or
   // missing strobe is caught, wherever it happens.
   always @(negedge clk) begin
      if (fill_we) fillCount++;
      if (resp_valid) respCount++;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [A-1:0] addr, input logic h,
                                input logic [3:0] vv, input logic ack, input logic [15:0] data);
      req_valid = v;
      req_addr  = addr;
      hit       = h;
      valid_vec = vv;
      mem_ack   = ack;
      mem_data  = data;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One complete miss. stall = number of ack-less cycles before word 1.
   // busyPulse raises a second miss request during FETCH.
   task automatic runMiss(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                          input logic [1:0] word, input logic [3:0] vv, input logic [1:0] expWay,
                          input logic [63:0] line, input int stall, input bit busyPulse);
      logic [A-1:0] addr;
      int fills0;
      int resps0;
      addr   = {tag, idx, word};
      fills0 = fillCount;
      resps0 = respCount;
      applyStimulus(1'b1, addr, 1'b0, vv, 1'b0, 16'h0000);
      tick;
      applyStimulus(1'b0, addr, 1'b0, vv, 1'b0, 16'h0000);
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin
            for (int s = 0; s < stall; s++) begin
               mem_ack  = 1'b0;
               mem_data = 16'hDEAD;
               checkOutput("stall_addr", 64'(mem_addr), 64'({tag, idx, 2'd1}));
               checkOutput("stall_rd", 64'(mem_rd_req), 64'd1);
               tick;
            end
         end
         mem_ack  = 1'b1;
         mem_data = line[16*k +: 16];
         if (busyPulse && (k == 1)) begin
            req_valid = 1'b1;
            req_addr  = {10'h3FF, 4'hA, 2'd0};
         end
         checkOutput("fetch_addr", 64'(mem_addr), 64'({tag, idx, 2'(k)}));
         checkOutput("fetch_rd", 64'(mem_rd_req), 64'd1);
         checkOutput("fetch_ready", 64'(req_ready), 64'd0);
         tick;
         req_valid = 1'b0;
      end
      mem_ack  = 1'b0;
      mem_data = 16'h0000;
      checkOutput("write_we", 64'(fill_we), 64'd1);
      checkOutput("write_way", 64'(fill_way), 64'(expWay));
      checkOutput("write_index", 64'(fill_index), 64'(idx));
      checkOutput("write_tag", 64'(fill_tag), 64'(tag));
      checkOutput("write_line", fill_line, line);
      checkOutput("write_resp", 64'(resp_valid), 64'd0);
      tick;
      checkOutput("resp_valid", 64'(resp_valid), 64'd1);
      checkOutput("resp_data", 64'(resp_data), 64'(line[16*word +: 16]));
      checkOutput("resp_we", 64'(fill_we), 64'd0);
      tick;
      checkOutput("idle_resp", 64'(resp_valid), 64'd0);
      checkOutput("idle_ready", 64'(req_ready), 64'd1);
      checkOutput("idle_rd", 64'(mem_rd_req), 64'd0);
      checkOutput("fill_pulses", 64'(fillCount - fills0), 64'd1);
      checkOutput("resp_pulses", 64'(respCount - resps0), 64'd1);
   endtask

   // Main sequence of directed scenarios
   initial begin
      int fills0;
      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 4'h0, 1'b0, 16'h0000);

      #12;
      checkOutput("rst_rd", 64'(mem_rd_req), 64'd0);
      checkOutput("rst_we", 64'(fill_we), 64'd0);
      checkOutput("rst_resp", 64'(resp_valid), 64'd0);
      checkOutput("rst_addr", 64'(mem_addr), 64'd0);
      checkOutput("rst_line", fill_line, 64'd0);
      checkOutput("rst_rdata", 64'(resp_data), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick;
      checkOutput("rst_ready", 64'(req_ready), 64'd1);

      $display("[TB] hit requests");
      applyStimulus(1'b1, {10'h155, 4'd3, 2'd2}, 1'b1, 4'hF, 1'b1, 16'hBEEF);
      for (int i = 0; i < 3; i++) begin
         tick;
         checkOutput("hit_ready", 64'(req_ready), 64'd1);
         checkOutput("hit_rd", 64'(mem_rd_req), 64'd0);
         checkOutput("hit_we", 64'(fill_we), 64'd0);
         checkOutput("hit_resp", 64'(resp_valid), 64'd0);
      end
      applyStimulus(1'b0, '0, 1'b0, 4'h0, 1'b0, 16'h0000);
      tick;

      $display("[TB] basic miss");
      runMiss(10'h155, 4'd3, 2'd2, 4'b0011, 2'd2, 64'h4444_3333_2222_1111, 0, 1'b0);
      runMiss(10'h0F0, 4'd3, 2'd0, 4'hF, 2'd0, 64'h0D0D_0C0C_0B0B_0A0A, 0, 1'b0);

      $display("[TB] round robin");
      for (int i = 0; i < 5; i++) begin
         runMiss(10'(10'h100 + i), 4'd5, 2'(i), 4'hF, 2'(i % 4),
                 {16'(i + 16'h7000), 16'hC0C0, 16'hB0B0, 16'(i + 16'h1000)}, 0, 1'b0);
      end
      runMiss(10'h066, 4'd6, 2'd3, 4'hF, 2'd0, 64'h1234_5678_9ABC_DEF0, 0, 1'b0);

      $display("[TB] stalled memory");
      runMiss(10'h2AA, 4'd7, 2'd1, 4'b0111, 2'd3, 64'h8888_7777_6666_5555, 3, 1'b0);

      $display("[TB] busy ignore");
      runMiss(10'h001, 4'd8, 2'd3, 4'b0000, 2'd0, 64'hFACE_CAFE_F00D_0001, 0, 1'b1);
      tick;
      checkOutput("busy_idle_rd", 64'(mem_rd_req), 64'd0);

      $display("[TB] reset mid fetch");
      fills0 = fillCount;
      applyStimulus(1'b1, {10'h3C3, 4'd5, 2'd3}, 1'b0, 4'hF, 1'b0, 16'h0000);
      tick;
      applyStimulus(1'b0, {10'h3C3, 4'd5, 2'd3}, 1'b0, 4'hF, 1'b1, 16'hAAAA);
      tick;
      mem_data = 16'hBBBB;
      tick;
      checkOutput("pre_rst_addr", 64'(mem_addr), 64'({10'h3C3, 4'd5, 2'd2}));
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_rd", 64'(mem_rd_req), 64'd0);
      checkOutput("mid_rst_we", 64'(fill_we), 64'd0);
      checkOutput("mid_rst_resp", 64'(resp_valid), 64'd0);
      checkOutput("mid_rst_addr", 64'(mem_addr), 64'd0);
      checkOutput("mid_rst_tag", 64'(fill_tag), 64'd0);
      checkOutput("mid_rst_index", 64'(fill_index), 64'd0);
      checkOutput("mid_rst_line", fill_line, 64'd0);
      checkOutput("mid_rst_rdata", 64'(resp_data), 64'd0);
      mem_data = 16'hCCCC;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         checkOutput("post_rst_we", 64'(fill_we), 64'd0);
         checkOutput("post_rst_rd", 64'(mem_rd_req), 64'd0);
         checkOutput("post_rst_ready", 64'(req_ready), 64'd1);
      end
      mem_ack = 1'b0;
      checkOutput("post_rst_fills", 64'(fillCount - fills0), 64'd0);
      runMiss(10'h3C3, 4'd5, 2'd3, 4'hF, 2'd0, 64'h4321_8765_CBA9_0FED, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
